// File: rtl/echo_delay_line.sv
`default_nettype none
// ============================================================================
// echo_delay_line : feedback echo, y = x/2 + (g/8)*y[n-D], optional ECHO_SATURATE_EN
// Revision 1.0
// ============================================================================
module echo_delay_line #(
  parameter int WIDTH            = 12,
  parameter int ADDR_BITS        = 13,
  parameter int SAMPLES_PER_STEP = 240,
  parameter int DELAY_BITS       = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] incoming_sample,
  input  logic [DELAY_BITS-1:0]   delay_amount,
  input  logic [2:0]              feedback,
  input  logic                    enable,
  output logic signed [WIDTH-1:0] modified_sample,
  output logic                    done,
  output logic                    busy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MIX   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [ADDR_BITS:0]   C_STEP     = (ADDR_BITS+1)'(SAMPLES_PER_STEP);
  localparam logic [ADDR_BITS:0]   C_MAX_D    = (ADDR_BITS+1)'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] C_FILL_MAX = ADDR_BITS'(DEPTH - 1);

  logic [2:0]              r_state;
  logic signed [WIDTH-1:0] r_x;
  logic [2:0]              r_g;
  logic [ADDR_BITS-1:0]    r_d;
  logic [ADDR_BITS-1:0]    r_wp;
  logic [ADDR_BITS-1:0]    r_fill;
  logic [ADDR_BITS-1:0]    r_raddr;
  logic signed [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0]        r_y;
  logic [WIDTH-1:0]        r_mem [DEPTH];

  logic [ADDR_BITS:0]      w_d_raw;
  logic [ADDR_BITS-1:0]    w_d;
  logic                    w_bypass;
  logic                    w_we;
  logic signed [WIDTH-1:0] w_tap;
  logic signed [WIDTH+2:0] w_x_ext;
  logic signed [WIDTH+2:0] w_tap_ext;
  logic signed [WIDTH+2:0] w_g_ext;
  logic signed [WIDTH+2:0] w_prod;
  logic signed [WIDTH+2:0] w_sum;
  logic [WIDTH-1:0]        w_y;

  assign w_d_raw  = C_STEP * (ADDR_BITS+1)'(delay_amount);
  assign w_d      = (w_d_raw > C_MAX_D) ? ADDR_BITS'(C_MAX_D) : ADDR_BITS'(w_d_raw);
  assign w_bypass = !enable || (delay_amount == '0);

  // An unprimed line position reads as silence rather than stale RAM.
  assign w_tap     = (r_fill >= r_d) ? r_dout : '0;
  assign w_x_ext   = {{3{r_x[WIDTH-1]}}, r_x};
  assign w_tap_ext = {{3{w_tap[WIDTH-1]}}, w_tap};
  assign w_g_ext   = {{WIDTH{1'b0}}, r_g};
  assign w_prod    = w_tap_ext * w_g_ext;
  assign w_sum     = (w_x_ext >>> 1) + (w_prod >>> 3);

`ifdef ECHO_SATURATE_EN
  localparam logic signed [WIDTH+2:0] C_POS = (WIDTH+3)'((1 <<< (WIDTH-1)) - 1);
  localparam logic signed [WIDTH+2:0] C_NEG = (WIDTH+3)'(-(1 <<< (WIDTH-1)));

  always_comb begin
    w_y = WIDTH'(w_sum);
    if (w_sum > C_POS) begin
      w_y = WIDTH'(C_POS);
    end else if (w_sum < C_NEG) begin
      w_y = WIDTH'(C_NEG);
    end
  end
`else
  assign w_y = WIDTH'(w_sum);
`endif

  // Write is gated by reset so an aborted transaction never touches the RAM.
  assign w_we = reset && (r_state == S_WRITE);

  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[r_wp] <= r_y;
    end
    r_dout <= r_mem[r_raddr];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      modified_sample <= '0;
      done            <= 1'b0;
      busy            <= 1'b0;
      r_wp            <= '0;
      r_fill          <= '0;
      r_d             <= '0;
      r_x             <= '0;
      r_g             <= '0;
      r_raddr         <= '0;
      r_y             <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bypass) begin
              modified_sample <= incoming_sample;
              done            <= 1'b1;
              r_fill          <= '0;
            end else begin
              r_x  <= incoming_sample;
              r_g  <= feedback;
              r_d  <= w_d;
              busy <= 1'b1;
              if (w_d != r_d) begin
                r_fill <= '0;
              end
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_raddr <= r_wp - r_d;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_state <= S_MIX;
        end
        S_MIX: begin
          r_y     <= w_y;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          modified_sample <= r_y;
          done            <= 1'b1;
          busy            <= 1'b0;
          r_wp            <= r_wp + 1'b1;
          if (r_fill != C_FILL_MAX) begin
            r_fill <= r_fill + 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_delay_line.sv
`default_nettype none
// ============================================================================
// tb_echo_delay_line : directed self-checking bench for echo_delay_line
// Revision 1.0
// ============================================================================
module tb_echo_delay_line;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic signed [11:0] incoming_sample = '0;
  logic [4:0]        delay_amount = '0;
  logic [2:0]        feedback = '0;
  logic              enable = 1'b0;
  logic signed [11:0] modified_sample;
  logic              done;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  echo_delay_line #(
    .WIDTH(12), .ADDR_BITS(13), .SAMPLES_PER_STEP(240), .DELAY_BITS(5)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .incoming_sample(incoming_sample), .delay_amount(delay_amount),
    .feedback(feedback), .enable(enable),
    .modified_sample(modified_sample), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One start pulse; lat counts edges after the sampling edge until done.
  task automatic step(input logic signed [11:0] x, output logic signed [11:0] y,
                      output int lat, output logic busy_seen);
    incoming_sample = x;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    busy_seen = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    y = modified_sample;
  endtask

  task automatic run_block(input string tag, input int n,
                           input logic signed [11:0] x, input logic signed [11:0] exp);
    logic signed [11:0] y;
    int lat;
    logic b;
    for (int i = 0; i < n; i++) begin
      step(x, y, lat, b);
      check(tag, y, exp);
      check({tag, " latency"}, lat, 4);
    end
  endtask

  initial begin
    logic signed [11:0] y;
    int lat;
    logic b;
    int dones;
    logic signed [11:0] y_seen;

    // Reset
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset sample", modified_sample, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    reset = 1'b1;

    // Bypass via enable=0, then via delay_amount=0
    enable = 1'b0; delay_amount = 5'd0; feedback = 3'd4;
    step(12'sd1000, y, lat, b);
    check("bypass y", y, 1000);
    check("bypass latency", lat, 0);
    check("bypass busy", b, 0);
    @(posedge clock); #1;
    check("bypass done one cycle", done, 0);
    enable = 1'b1;
    step(-12'sd6, y, lat, b);
    check("bypass d0 y", y, -6);
    check("bypass d0 latency", lat, 0);

    // Priming with delay 240, gain 4/8
    delay_amount = 5'd1; feedback = 3'd4;
    step(12'sd800, y, lat, b);
    check("s2 first y", y, 400);
    check("s2 first latency", lat, 4);
    check("s2 busy", b, 1);
    check("s2 busy after done", busy, 0);
    run_block("s2 prime", 239, 12'sd800, 12'sd400);
    step(12'sd0, y, lat, b);
    check("s2 echo 241", y, 200);
    check("s2 echo latency", lat, 4);
    run_block("s2 echo", 3, 12'sd0, 12'sd200);

    // Delay change re-primes: 480 silent-tap outputs, echo at 481
    delay_amount = 5'd2;
    run_block("s3 reprime", 480, -12'sd101, -12'sd51);
    step(12'sd0, y, lat, b);
    check("s3 echo 481", y, -26);

    // Extra start pulses while busy are ignored
    check("s4 wp before", dut.r_wp, 725);
    incoming_sample = 12'sd0;
    dones = 0;
    y_seen = '0;
    start = 1'b1;
    for (int e = 0; e < 9; e++) begin
      @(posedge clock); #1;
      if (e == 3) start = 1'b0;
      if (e == 0) check("s4 busy", busy, 1);
      if (done === 1'b1) begin
        dones++;
        y_seen = modified_sample;
      end
    end
    check("s4 done count", dones, 1);
    check("s4 wp after", dut.r_wp, 726);
    check("s4 y", y_seen, -26);

    // Gain 7/8 with full-scale input
    delay_amount = 5'd1; feedback = 3'd7;
    run_block("s5 period1", 240, 12'sd2047, 12'sd1023);
    run_block("s5 period2", 240, 12'sd2047, 12'sd1918);
`ifdef ECHO_SATURATE_EN
    run_block("s5 period3", 240, 12'sd2047, 12'sd2047);
    run_block("s5 period4", 240, 12'sd2047, 12'sd2047);
`else
    run_block("s5 period3", 240, 12'sd2047, -12'sd1395);
    run_block("s5 period4", 240, 12'sd2047, -12'sd198);
`endif

    // Reset asserted while in MIX aborts the transaction
    incoming_sample = 12'sd100;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    dones = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clock); #1;
      if (done === 1'b1) dones++;
    end
    check("s6 done count", dones, 0);
    check("s6 sample", modified_sample, 0);
    check("s6 busy", busy, 0);
    check("s6 wp", dut.r_wp, 0);
    reset = 1'b1;
    step(12'sd500, y, lat, b);
    check("s6 next y", y, 250);
    check("s6 next latency", lat, 4);
    check("s6 wp after", dut.r_wp, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
